// File: rtl/arch_map_recovery_ctrl_pkg.sv
// Shared types and constants for the architectural-map recovery sequencer.
// Consumed by the interface and the controller via a wildcard import.
package arch_map_recovery_ctrl_pkg;

    localparam int ARCH_REGS = 32;
    localparam int IDX_W     = $clog2(ARCH_REGS);
    localparam int TAG_W     = 6;

    typedef logic [TAG_W-1:0] TAG;
    typedef logic [IDX_W-1:0] ARCH_REG_IDX;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } recov_state_e;

    localparam ARCH_REG_IDX LAST_IDX = ARCH_REG_IDX'(ARCH_REGS - 1);

endpackage

// File: rtl/arch_map_recovery_ctrl_if.sv
// Bundle of recovery-control, arch_map read port, map-table restore and debug signals.
// Perf counter outputs exist only when RECOVERY_PERF_EN is defined.
interface arch_map_recovery_ctrl_if;
    import arch_map_recovery_ctrl_pkg::*;

    logic        recover_req;
    logic        retire_en;
    ARCH_REG_IDX arch_read_idx;
    TAG          arch_read_out;
    logic        mt_wr_en;
    ARCH_REG_IDX mt_wr_idx;
    TAG          mt_wr_tag;
    logic        stall_dispatch;
    logic        recover_busy;
    logic        recover_done;
    logic        proto_err;
    logic        dbg_req;
    ARCH_REG_IDX dbg_idx;
    logic        dbg_grant;
    TAG          dbg_data;
`ifdef RECOVERY_PERF_EN
    logic [15:0] recover_count;
    logic [31:0] stall_cycles;
`endif

    // master is the recovery controller; slave is the ROB / arch_map / debug side.
    modport master (
        input  recover_req, retire_en, arch_read_out, dbg_req, dbg_idx,
        output arch_read_idx, mt_wr_en, mt_wr_idx, mt_wr_tag, stall_dispatch,
               recover_busy, recover_done, proto_err, dbg_grant, dbg_data
`ifdef RECOVERY_PERF_EN
        , output recover_count, stall_cycles
`endif
    );

    modport slave (
        output recover_req, retire_en, arch_read_out, dbg_req, dbg_idx,
        input  arch_read_idx, mt_wr_en, mt_wr_idx, mt_wr_tag, stall_dispatch,
               recover_busy, recover_done, proto_err, dbg_grant, dbg_data
`ifdef RECOVERY_PERF_EN
        , input recover_count, stall_cycles
`endif
    );

endinterface

// File: rtl/arch_map_recovery_ctrl.sv
// Walks the architectural map into the speculative map table after a flush and
// lends the arch_map read port to a debug requester when idle. Optional: RECOVERY_PERF_EN.
module arch_map_recovery_ctrl
    import arch_map_recovery_ctrl_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    arch_map_recovery_ctrl_if.master  bus
);

    recov_state_e state_reg, state_next;
    ARCH_REG_IDX  idx_reg, idx_next;
    logic         proto_err_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            // The arch_map must be frozen while it is being copied out.
            if (bus.retire_en && (state_reg != IDLE))
                proto_err_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (bus.recover_req) begin
                    state_next = WALK;
                    idx_next   = '0;
                end
            end
            WALK: begin
                // recover_req is deliberately ignored: the source map cannot change mid-walk.
                idx_next = idx_reg + ARCH_REG_IDX'(1);
                if (idx_reg == LAST_IDX)
                    state_next = DONE;
            end
            DONE: begin
                state_next = bus.recover_req ? WALK : IDLE;
                idx_next   = '0;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    logic dbg_grant_c;

    always_comb begin
        bus.arch_read_idx  = bus.dbg_idx;
        bus.mt_wr_en       = 1'b0;
        bus.mt_wr_idx      = '0;
        bus.mt_wr_tag      = '0;
        bus.stall_dispatch = 1'b0;
        bus.recover_busy   = 1'b0;
        bus.recover_done   = 1'b0;
        dbg_grant_c        = 1'b0;
        case (state_reg)
            IDLE: begin
                // A recovery request in the same cycle wins the read port.
                dbg_grant_c = bus.dbg_req & ~bus.recover_req;
            end
            WALK: begin
                bus.arch_read_idx  = idx_reg;
                bus.mt_wr_en       = 1'b1;
                bus.mt_wr_idx      = idx_reg;
                bus.mt_wr_tag      = bus.arch_read_out;
                bus.stall_dispatch = 1'b1;
                bus.recover_busy   = 1'b1;
            end
            DONE: begin
                bus.stall_dispatch = 1'b1;
                bus.recover_done   = 1'b1;
            end
            default: begin
                dbg_grant_c = 1'b0;
            end
        endcase
    end

    assign bus.dbg_grant = dbg_grant_c;
    assign bus.dbg_data  = dbg_grant_c ? bus.arch_read_out : '0;
    assign bus.proto_err = proto_err_reg;

`ifdef RECOVERY_PERF_EN
    logic [15:0] recover_count_reg;
    logic [31:0] stall_cycles_reg;
    logic        walk_entry;

    assign walk_entry = (state_next == WALK) && (state_reg != WALK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            recover_count_reg <= '0;
            stall_cycles_reg  <= '0;
        end else begin
            if (walk_entry && (recover_count_reg != '1))
                recover_count_reg <= recover_count_reg + 16'd1;
            if ((state_reg != IDLE) && (stall_cycles_reg != '1))
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign bus.recover_count = recover_count_reg;
    assign bus.stall_cycles  = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_arch_map_recovery_ctrl.sv
// Randomized and directed bench for arch_map_recovery_ctrl against a schedule-queue
// reference model; also checks the RECOVERY_PERF_EN counters when that macro is defined.
module tb_arch_map_recovery_ctrl;
    import arch_map_recovery_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    arch_map_recovery_ctrl_if bus();

    arch_map_recovery_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Architectural map seen by the DUT through its combinational read port.
    TAG arch_map [ARCH_REGS];
    assign bus.arch_read_out = arch_map[bus.arch_read_idx];

    // Reference: queue of per-cycle obligations; 0..ARCH_REGS-1 = write that index,
    // ARCH_REGS = completion cycle, empty = idle.
    int          exp_q[$];
    bit          proto_exp;
    int          exp_recov;
    int          exp_stall;
    int          checks;
    int          errors;
    int          wr_seen;
    int          cyc;
    ARCH_REG_IDX retire_idx;
    TAG          retire_tag;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        proto_exp = 1'b0;
        exp_recov = 0;
        exp_stall = 0;
        wr_seen   = 0;
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        int          head;
        logic [11:0] e_wr;
        logic [2:0]  e_ctl;
        logic [6:0]  e_dbg;
        ARCH_REG_IDX e_ridx;
        logic        g;
        bit          busy_m;
        bit          accept;
        if (!reset) model_clear();
        @(negedge clock);
        head = (exp_q.size() != 0) ? exp_q[0] : -1;
        if (head >= 0 && head < ARCH_REGS) begin
            e_wr   = {1'b1, ARCH_REG_IDX'(head), arch_map[head]};
            e_ctl  = 3'b110;
            e_dbg  = '0;
            e_ridx = ARCH_REG_IDX'(head);
        end else if (head == ARCH_REGS) begin
            e_wr   = '0;
            e_ctl  = 3'b101;
            e_dbg  = '0;
            e_ridx = bus.dbg_idx;
        end else begin
            g      = bus.dbg_req & ~bus.recover_req;
            e_wr   = '0;
            e_ctl  = 3'b000;
            e_dbg  = {g, g ? arch_map[bus.dbg_idx] : TAG'(0)};
            e_ridx = bus.dbg_idx;
        end
        chk("mt_write", 64'({bus.mt_wr_en, bus.mt_wr_idx, bus.mt_wr_tag}), 64'(e_wr));
        chk("stall_busy_done", 64'({bus.stall_dispatch, bus.recover_busy, bus.recover_done}), 64'(e_ctl));
        chk("dbg", 64'({bus.dbg_grant, bus.dbg_data}), 64'(e_dbg));
        chk("read_idx", 64'(bus.arch_read_idx), 64'(e_ridx));
        chk("proto_err", 64'(bus.proto_err), 64'(proto_exp));
`ifdef RECOVERY_PERF_EN
        chk("recover_count", 64'(bus.recover_count), 64'(exp_recov));
        chk("stall_cycles", 64'(bus.stall_cycles), 64'(exp_stall));
`endif
        if (bus.mt_wr_en) wr_seen++;
        if (bus.recover_done) begin
            chk("write_count", 64'(wr_seen), 64'(ARCH_REGS));
            $display("recovery done cycle %0d writes %0d", cyc, wr_seen);
            wr_seen = 0;
        end
        @(posedge clock);
        if (reset) begin
            busy_m = (exp_q.size() != 0);
            accept = bus.recover_req && (!busy_m || exp_q[0] == ARCH_REGS);
            if (bus.retire_en && busy_m) proto_exp = 1'b1;
            if (bus.retire_en && !busy_m) arch_map[retire_idx] = retire_tag;
            if (busy_m) begin
                exp_stall++;
                void'(exp_q.pop_front());
            end
            if (accept) begin
                for (int i = 0; i <= ARCH_REGS; i++) exp_q.push_back(i);
                exp_recov++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic retire(input int r, input int t);
        bus.retire_en = 1'b1;
        retire_idx    = ARCH_REG_IDX'(r);
        retire_tag    = TAG'(t);
        step();
        bus.retire_en = 1'b0;
    endtask

    task automatic pulse_recover();
        bus.recover_req = 1'b1;
        step();
        bus.recover_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * ARCH_REGS && exp_q.size() != 0; i++) step();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        model_clear();
        for (int i = 0; i < ARCH_REGS; i++) arch_map[i] = TAG'(i);
        retire_idx      = '0;
        retire_tag      = '0;
        bus.recover_req = 1'b1;
        bus.retire_en   = 1'b0;
        bus.dbg_req     = 1'b1;
        bus.dbg_idx     = ARCH_REG_IDX'(7);

        // Held in reset with requests active.
        repeat (3) step();
        reset           = 1'b1;
        bus.recover_req = 1'b0;
        step();
        chk("dbg_grant_after_reset", 64'(bus.dbg_grant), 64'(1));
        chk("dbg_data_after_reset", 64'(bus.dbg_data), 64'(7));

        // Full recovery with two retired mappings, debug held high throughout.
        retire(3, 40);
        retire(31, 63);
        repeat (3) step();
        pulse_recover();
        drain();
        bus.dbg_idx = ARCH_REG_IDX'(3);
        step();
        chk("dbg_reads_r3", 64'(bus.dbg_data), 64'(40));

        // Re-trigger inside the walk is ignored; re-trigger in DONE starts a new walk.
        pulse_recover();
        repeat (15) step();
        pulse_recover();
        for (int i = 0; i < 4 * ARCH_REGS && !(exp_q.size() != 0 && exp_q[0] == ARCH_REGS); i++) step();
        pulse_recover();
        chk("restart_idx0", 64'({bus.mt_wr_en, bus.mt_wr_idx}), 64'({1'b1, ARCH_REG_IDX'(0)}));
        drain();

        // Asynchronous reset in the middle of a walk.
        pulse_recover();
        repeat (12) step();
        reset = 1'b0;
        #1;
        chk("midwalk_reset_wr_en", 64'(bus.mt_wr_en), 64'(0));
        chk("midwalk_reset_stall", 64'(bus.stall_dispatch), 64'(0));
        step();
        reset = 1'b1;
        repeat (5) step();

        // Randomized traffic; retires only issued while the model is idle.
        for (int n = 0; n < 1500; n++) begin
            bus.recover_req = ($urandom_range(0, 29) == 0);
            bus.dbg_req     = 1'($urandom_range(0, 1));
            bus.dbg_idx     = ARCH_REG_IDX'($urandom);
            bus.retire_en   = (exp_q.size() == 0) && ($urandom_range(0, 3) == 0);
            retire_idx      = ARCH_REG_IDX'($urandom);
            retire_tag      = TAG'($urandom);
            step();
        end
        bus.recover_req = 1'b0;
        bus.retire_en   = 1'b0;
        drain();

        // Counters from a clean reset across two recoveries.
        reset = 1'b0;
        step();
        reset = 1'b1;
        pulse_recover();
        drain();
        pulse_recover();
        drain();
`ifdef RECOVERY_PERF_EN
        chk("perf_recover_count", 64'(bus.recover_count), 64'(2));
        chk("perf_stall_cycles", 64'(bus.stall_cycles), 64'(66));
`endif

        // Retire during a walk raises a sticky protocol error.
        pulse_recover();
        repeat (5) step();
        bus.retire_en = 1'b1;
        retire_idx    = ARCH_REG_IDX'(9);
        retire_tag    = TAG'(50);
        step();
        bus.retire_en = 1'b0;
        drain();
        repeat (3) step();
        chk("proto_err_sticky", 64'(bus.proto_err), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
